wt_mac_accum: RTL

WT_MAC_ACCUM -- requirements
Module: wt_mac_accum

---
 rtl/wt_mac_accum_pkg.sv | 17 +
 rtl/wt_mac_accum_add.sv | 36 +++
 rtl/wt_mac_accum.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wt_mac_accum_pkg.sv
// -----------------------------------------------------------------------------
// wt_mac_accum_pkg
// Shared definitions for the Wallace-product accumulator:
//   - state_e : FSM state encoding (IDLE=0, ACCUM=1, HOLD=2)
//   - PROD_W  : width of the product arriving from the 16x16 multiplier
// -----------------------------------------------------------------------------
package wt_mac_accum_pkg;

    localparam int unsigned PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage : wt_mac_accum_pkg

// File: rtl/wt_mac_accum_add.sv
// -----------------------------------------------------------------------------
// mac_add_sat
// Adds a zero-extended PROD_W-bit product to an ACC_W-bit running sum and
// reports the carry out of the top accumulator bit.
//   a_i   : ACC_W-bit running sum
//   b_i   : PROD_W-bit unsigned product
//   sum_o : ACC_W-bit result (wrapped when SAT=0, clamped to all-ones when SAT=1)
//   ovf_o : carry out of bit ACC_W-1
// -----------------------------------------------------------------------------
module mac_add_sat
    import wt_mac_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned SAT   = 0
) (
    input  logic [ACC_W-1:0]  a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    // One extra bit captures the carry out of the accumulator's MSB.
    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, b_i};
    assign ovf_o    = full_sum[ACC_W];

    if (SAT != 0) begin : g_clamp
        // Once clamped, any further non-zero add carries again and re-clamps,
        // so the sum stays at all-ones for the rest of the block.
        assign sum_o = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
    end else begin : g_wrap
        assign sum_o = full_sum[ACC_W-1:0];
    end

endmodule : mac_add_sat

// File: rtl/wt_mac_accum.sv
// -----------------------------------------------------------------------------
// wt_mac_accum
// Accumulates a block of unsigned 32-bit products (one per accepted beat) and
// presents the sum, beat count and a sticky overflow flag until the consumer
// takes it.
//   clk       : clock, rising edge
//   clrn      : asynchronous active-low reset
//   in_valid  : product beat valid
//   in_ready  : beat accepted this cycle (low while a result is held)
//   z         : unsigned product
//   in_last   : accepted beat closes the block
//   clr       : synchronous abort/clear, overrides every other input
//   out_valid : result held (registered, HOLD state)
//   out_ready : consumer takes the result
//   acc       : accumulated sum
//   cnt       : beats accepted in the current block (saturates at 16'hFFFF)
//   ovf       : sticky overflow for the current block
// -----------------------------------------------------------------------------
module wt_mac_accum
    import wt_mac_accum_pkg::*;
#(
    parameter int unsigned ACC_W = 40,  // legal range 33..64
    parameter int unsigned SAT   = 0    // 0 = wrap, 1 = clamp to all-ones
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] z,
    input  logic              in_last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc,
    output logic [15:0]       cnt,
    output logic              ovf
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [15:0]        cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               beat;

    mac_add_sat #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (z),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign in_ready = (state_q != ST_HOLD);
    assign beat     = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (beat) begin
                        acc_d   = {{(ACC_W - PROD_W){1'b0}}, z};
                        cnt_d   = 16'd1;
                        ovf_d   = 1'b0;
                        state_d = in_last ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc_d   = add_sum;
                        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        ovf_d   = ovf_q | add_ovf;
                        state_d = in_last ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    // Result is frozen; input beats are not accepted here.
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // out_valid comes straight from a flop, one cycle after the last beat.
    assign out_valid_d = (state_d == ST_HOLD);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign cnt       = cnt_q;
    assign ovf       = ovf_q;

endmodule : wt_mac_accum
